// File: rtl/data_chk_interleaver.sv
// Merges groups of BEATS_PER_CHK data beats with one checksum beat into a single registered output stream.
// Define DATA_CHK_ID_CHECK_EN to enable the sticky per-group stream-id consistency flag chk_err.
module data_chk_interleaver #(
    parameter int DATA_W         = 512,
    parameter int ID_W           = 6,
    parameter int BEATS_PER_CHK  = 4,
    localparam int KEEP_W        = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_data,
    input  logic [KEEP_W-1:0] inp_keep,
    input  logic [ID_W-1:0]   inp_id,
    input  logic              inp_valid,
    output logic              inp_ready,
    input  logic [DATA_W-1:0] chk_data,
    input  logic [KEEP_W-1:0] chk_keep,
    input  logic [ID_W-1:0]   chk_id,
    input  logic              chk_last,
    input  logic              chk_valid,
    output logic              chk_ready,
    output logic [DATA_W-1:0] out,
    output logic [KEEP_W-1:0] out_keep,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              chk_err
);

    localparam int CNT_W = (BEATS_PER_CHK > 1) ? $clog2(BEATS_PER_CHK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_CHK - 1);

    typedef enum logic {
        ST_DATA,
        ST_CHK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             free;
    logic             inp_xfer;
    logic             chk_xfer;

    // The single output register can take a new beat whenever it is empty or draining this cycle.
    assign free      = !out_valid || out_ready;
    assign inp_ready = (state == ST_DATA) && free;
    assign chk_ready = (state == ST_CHK) && free;
    assign inp_xfer  = inp_valid && inp_ready;
    assign chk_xfer  = chk_valid && chk_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_DATA;
            beat_cnt  <= '0;
            out       <= '0;
            out_keep  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (inp_xfer) begin
                out       <= inp_data;
                out_keep  <= inp_keep;
                out_id    <= inp_id;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
                if (beat_cnt == LAST_CNT) begin
                    beat_cnt <= '0;
                    state    <= ST_CHK;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end else if (chk_xfer) begin
                out       <= chk_data;
                out_keep  <= chk_keep;
                out_id    <= chk_id;
                out_last  <= chk_last;
                out_valid <= 1'b1;
                beat_cnt  <= '0;
                state     <= ST_DATA;
            end else if (free) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DATA_CHK_ID_CHECK_EN
    logic [ID_W-1:0] grp_id;
    logic            id_mismatch;

    // The first data beat of a group defines the id every later beat of that group must carry.
    always_comb begin
        id_mismatch = 1'b0;
        if (inp_xfer && (beat_cnt != '0) && (inp_id != grp_id)) begin
            id_mismatch = 1'b1;
        end
        if (chk_xfer && (chk_id != grp_id)) begin
            id_mismatch = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grp_id  <= '0;
            chk_err <= 1'b0;
        end else begin
            if (inp_xfer && (beat_cnt == '0)) begin
                grp_id <= inp_id;
            end
            if (id_mismatch) begin
                chk_err <= 1'b1;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_chk_interleaver.sv
// Table-driven bench for data_chk_interleaver: a BEATS_PER_CHK=4 instance for the main
// vectors, reset and id checks, plus a BEATS_PER_CHK=1 instance for strict alternation.
module tb_data_chk_interleaver;

    localparam int DATA_W = 512;
    localparam int ID_W   = 6;
    localparam int KEEP_W = DATA_W / 8;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [ID_W-1:0] I0  = 6'd0;
    localparam logic [ID_W-1:0] I3  = 6'd3;
    localparam logic [ID_W-1:0] I5  = 6'd5;
    localparam logic [ID_W-1:0] I7  = 6'd7;
    localparam logic [ID_W-1:0] I9  = 6'd9;
    localparam logic [ID_W-1:0] I12 = 6'd12;

`ifdef DATA_CHK_ID_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [DATA_W-1:0] inp_data, chk_data, out;
    logic [KEEP_W-1:0] inp_keep, chk_keep, out_keep;
    logic [ID_W-1:0]   inp_id, chk_id, out_id;
    logic inp_valid, inp_ready, chk_last, chk_valid, chk_ready;
    logic out_last, out_valid, out_ready, chk_err;

    logic [DATA_W-1:0] b_inp_data, b_chk_data, b_out;
    logic [KEEP_W-1:0] b_inp_keep, b_chk_keep, b_out_keep;
    logic [ID_W-1:0]   b_inp_id, b_chk_id, b_out_id;
    logic b_inp_valid, b_inp_ready, b_chk_last, b_chk_valid, b_chk_ready;
    logic b_out_last, b_out_valid, b_out_ready, b_chk_err;

    data_chk_interleaver #(.DATA_W(DATA_W), .ID_W(ID_W), .BEATS_PER_CHK(4)) dut (
        .clock(clock), .reset(reset),
        .inp_data(inp_data), .inp_keep(inp_keep), .inp_id(inp_id),
        .inp_valid(inp_valid), .inp_ready(inp_ready),
        .chk_data(chk_data), .chk_keep(chk_keep), .chk_id(chk_id), .chk_last(chk_last),
        .chk_valid(chk_valid), .chk_ready(chk_ready),
        .out(out), .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .chk_err(chk_err)
    );

    data_chk_interleaver #(.DATA_W(DATA_W), .ID_W(ID_W), .BEATS_PER_CHK(1)) dut_alt (
        .clock(clock), .reset(reset),
        .inp_data(b_inp_data), .inp_keep(b_inp_keep), .inp_id(b_inp_id),
        .inp_valid(b_inp_valid), .inp_ready(b_inp_ready),
        .chk_data(b_chk_data), .chk_keep(b_chk_keep), .chk_id(b_chk_id), .chk_last(b_chk_last),
        .chk_valid(b_chk_valid), .chk_ready(b_chk_ready),
        .out(b_out), .out_keep(b_out_keep), .out_id(b_out_id), .out_last(b_out_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .chk_err(b_chk_err)
    );

    typedef struct {
        logic            iv;
        logic [7:0]      itag;
        logic [ID_W-1:0] iid;
        logic            cv;
        logic [7:0]      ctag;
        logic [ID_W-1:0] cid;
        logic            clast;
        logic            ordy;
        logic            e_iready;
        logic            e_cready;
        logic            e_ov;
        logic [7:0]      e_tag;
        logic [ID_W-1:0] e_id;
        logic            e_last;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int passed = 0;

    function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] tag);
        return {KEEP_W{tag}};
    endfunction

    function automatic logic [KEEP_W-1:0] mk_keep(input logic [7:0] tag);
        return {(KEEP_W/8){tag}};
    endfunction

    function automatic vec_t mkv(input logic iv, input logic [7:0] itag, input logic [ID_W-1:0] iid,
                                 input logic cv, input logic [7:0] ctag, input logic [ID_W-1:0] cid,
                                 input logic clast, input logic ordy,
                                 input logic eir, input logic ecr, input logic eov,
                                 input logic [7:0] etag, input logic [ID_W-1:0] eid, input logic elast);
        vec_t v;
        v.iv = iv; v.itag = itag; v.iid = iid;
        v.cv = cv; v.ctag = ctag; v.cid = cid; v.clast = clast; v.ordy = ordy;
        v.e_iready = eir; v.e_cready = ecr; v.e_ov = eov;
        v.e_tag = etag; v.e_id = eid; v.e_last = elast;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check readies before the rising edge and the register after it.
    task automatic apply_stimulus(input vec_t v, input int row);
        @(negedge clock);
        inp_valid = v.iv; inp_data = mk_data(v.itag); inp_keep = mk_keep(v.itag); inp_id = v.iid;
        chk_valid = v.cv; chk_data = mk_data(v.ctag); chk_keep = mk_keep(v.ctag); chk_id = v.cid;
        chk_last  = v.clast;
        out_ready = v.ordy;
        #1;
        check_output($sformatf("row%0d inp_ready", row), DATA_W'(inp_ready), DATA_W'(v.e_iready));
        check_output($sformatf("row%0d chk_ready", row), DATA_W'(chk_ready), DATA_W'(v.e_cready));
        @(posedge clock);
        #1;
        check_output($sformatf("row%0d out_valid", row), DATA_W'(out_valid), DATA_W'(v.e_ov));
        if (v.e_ov) begin
            check_output($sformatf("row%0d out", row), out, mk_data(v.e_tag));
            check_output($sformatf("row%0d out_keep", row), DATA_W'(out_keep), DATA_W'(mk_keep(v.e_tag)));
            check_output($sformatf("row%0d out_id", row), DATA_W'(out_id), DATA_W'(v.e_id));
            check_output($sformatf("row%0d out_last", row), DATA_W'(out_last), DATA_W'(v.e_last));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " out_valid"}, DATA_W'(out_valid), '0);
        check_output({tag, " out"}, out, '0);
        check_output({tag, " out_keep"}, DATA_W'(out_keep), '0);
        check_output({tag, " out_id"}, DATA_W'(out_id), '0);
        check_output({tag, " out_last"}, DATA_W'(out_last), '0);
        check_output({tag, " chk_err"}, DATA_W'(chk_err), '0);
        check_output({tag, " inp_ready"}, DATA_W'(inp_ready), DATA_W'(1'b1));
        check_output({tag, " chk_ready"}, DATA_W'(chk_ready), '0);
    endtask

    initial begin
        logic [7:0] dq[3];
        logic [7:0] cq[3];
        logic [7:0] exp_seq[4];
        int di;
        int ci;
        logic ir;
        logic cr;

        reset = 1'b0;
        inp_valid = 1'b0; inp_data = '0; inp_keep = '0; inp_id = '0;
        chk_valid = 1'b0; chk_data = '0; chk_keep = '0; chk_id = '0; chk_last = 1'b0;
        out_ready = 1'b1;
        b_inp_valid = 1'b0; b_inp_data = '0; b_inp_keep = '0; b_inp_id = '0;
        b_chk_valid = 1'b0; b_chk_data = '0; b_chk_keep = '0; b_chk_id = '0; b_chk_last = 1'b0;
        b_out_ready = 1'b1;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Full group, chk_valid waiting early, stray data during CHK, and backpressure on data and checksum.
        vecs.push_back(mkv(H,8'h10,I5, L,8'h00,I5,L, H, H,L,H,8'h10,I5,L));
        vecs.push_back(mkv(H,8'h11,I5, L,8'h00,I5,L, H, H,L,H,8'h11,I5,L));
        vecs.push_back(mkv(H,8'h12,I5, L,8'h00,I5,L, H, H,L,H,8'h12,I5,L));
        vecs.push_back(mkv(H,8'h13,I5, L,8'h00,I5,L, H, H,L,H,8'h13,I5,L));
        vecs.push_back(mkv(L,8'h00,I5, H,8'hC0,I5,H, H, L,H,H,8'hC0,I5,H));
        vecs.push_back(mkv(L,8'h00,I5, L,8'h00,I5,L, H, H,L,L,8'h00,I0,L));
        vecs.push_back(mkv(H,8'h20,I9, H,8'hC1,I9,H, H, H,L,H,8'h20,I9,L));
        vecs.push_back(mkv(H,8'h21,I9, H,8'hC1,I9,H, H, H,L,H,8'h21,I9,L));
        vecs.push_back(mkv(H,8'h22,I9, H,8'hC1,I9,H, H, H,L,H,8'h22,I9,L));
        vecs.push_back(mkv(H,8'h23,I9, H,8'hC1,I9,H, H, H,L,H,8'h23,I9,L));
        vecs.push_back(mkv(H,8'h30,I12, H,8'hC1,I9,H, H, L,H,H,8'hC1,I9,H));
        vecs.push_back(mkv(H,8'h30,I12, L,8'h00,I12,L, H, H,L,H,8'h30,I12,L));
        vecs.push_back(mkv(H,8'h31,I12, L,8'h00,I12,L, H, H,L,H,8'h31,I12,L));
        vecs.push_back(mkv(H,8'h32,I12, L,8'h00,I12,L, L, L,L,H,8'h31,I12,L));
        vecs.push_back(mkv(H,8'h32,I12, L,8'h00,I12,L, L, L,L,H,8'h31,I12,L));
        vecs.push_back(mkv(H,8'h32,I12, L,8'h00,I12,L, L, L,L,H,8'h31,I12,L));
        vecs.push_back(mkv(H,8'h32,I12, L,8'h00,I12,L, H, H,L,H,8'h32,I12,L));
        vecs.push_back(mkv(H,8'h33,I12, L,8'h00,I12,L, H, H,L,H,8'h33,I12,L));
        vecs.push_back(mkv(L,8'h00,I12, H,8'hC2,I12,L, L, L,L,H,8'h33,I12,L));
        vecs.push_back(mkv(L,8'h00,I12, H,8'hC2,I12,L, H, L,H,H,8'hC2,I12,L));
        vecs.push_back(mkv(L,8'h00,I12, L,8'h00,I12,L, L, L,L,H,8'hC2,I12,L));
        vecs.push_back(mkv(L,8'h00,I12, L,8'h00,I12,L, H, H,L,L,8'h00,I0,L));

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], i);
        end
        check_output("table chk_err", DATA_W'(chk_err), '0);

        // Reset in the middle of a group must drop the partial group immediately.
        apply_stimulus(mkv(H,8'h60,I3, L,8'h00,I3,L, H, H,L,H,8'h60,I3,L), 100);
        apply_stimulus(mkv(H,8'h61,I3, L,8'h00,I3,L, H, H,L,H,8'h61,I3,L), 101);
        apply_stimulus(mkv(H,8'h62,I3, L,8'h00,I3,L, H, H,L,H,8'h62,I3,L), 102);
        @(negedge clock);
        inp_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clock);
        reset = 1'b1;
        apply_stimulus(mkv(H,8'h70,I3, H,8'hD0,I3,H, H, H,L,H,8'h70,I3,L), 110);
        apply_stimulus(mkv(H,8'h71,I3, H,8'hD0,I3,H, H, H,L,H,8'h71,I3,L), 111);
        apply_stimulus(mkv(H,8'h72,I3, H,8'hD0,I3,H, H, H,L,H,8'h72,I3,L), 112);
        apply_stimulus(mkv(H,8'h73,I3, H,8'hD0,I3,H, H, H,L,H,8'h73,I3,L), 113);
        apply_stimulus(mkv(L,8'h00,I3, H,8'hD0,I3,H, H, L,H,H,8'hD0,I3,H), 114);

        // Checksum id differing from the group id sets the sticky error only when the check is built in.
        apply_stimulus(mkv(H,8'h80,I5, L,8'h00,I5,L, H, H,L,H,8'h80,I5,L), 120);
        apply_stimulus(mkv(H,8'h81,I5, L,8'h00,I5,L, H, H,L,H,8'h81,I5,L), 121);
        apply_stimulus(mkv(H,8'h82,I5, L,8'h00,I5,L, H, H,L,H,8'h82,I5,L), 122);
        apply_stimulus(mkv(H,8'h83,I5, L,8'h00,I5,L, H, H,L,H,8'h83,I5,L), 123);
        check_output("idcheck before chk", DATA_W'(chk_err), '0);
        apply_stimulus(mkv(L,8'h00,I5, H,8'hE0,I7,L, H, L,H,H,8'hE0,I7,L), 124);
        check_output("idcheck after chk", DATA_W'(chk_err), DATA_W'(EXP_ERR));
        apply_stimulus(mkv(L,8'h00,I5, L,8'h00,I5,L, H, H,L,L,8'h00,I0,L), 125);
        check_output("idcheck sticky", DATA_W'(chk_err), DATA_W'(EXP_ERR));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("idcheck reset clears", DATA_W'(chk_err), '0);
        @(negedge clock);
        reset = 1'b1;

        // One data beat per group: both ports offer beats every cycle, output must alternate.
        dq[0] = 8'h40; dq[1] = 8'h41; dq[2] = 8'h00;
        cq[0] = 8'h50; cq[1] = 8'h51; cq[2] = 8'h00;
        exp_seq[0] = 8'h40; exp_seq[1] = 8'h50; exp_seq[2] = 8'h41; exp_seq[3] = 8'h51;
        di = 0;
        ci = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            b_inp_valid = (di < 2); b_inp_data = mk_data(dq[di]); b_inp_keep = mk_keep(dq[di]); b_inp_id = I5;
            b_chk_valid = (ci < 2); b_chk_data = mk_data(cq[ci]); b_chk_keep = mk_keep(cq[ci]); b_chk_id = I5;
            b_chk_last = 1'b1;
            #1;
            ir = b_inp_ready;
            cr = b_chk_ready;
            check_output($sformatf("alt%0d inp_ready", k), DATA_W'(ir), DATA_W'((k % 2) == 0));
            check_output($sformatf("alt%0d chk_ready", k), DATA_W'(cr), DATA_W'((k % 2) == 1));
            @(posedge clock);
            #1;
            if (ir && b_inp_valid) di++;
            if (cr && b_chk_valid) ci++;
            check_output($sformatf("alt%0d out_valid", k), DATA_W'(b_out_valid), DATA_W'(1'b1));
            check_output($sformatf("alt%0d out", k), b_out, mk_data(exp_seq[k]));
            check_output($sformatf("alt%0d out_last", k), DATA_W'(b_out_last), DATA_W'((k % 2) == 1));
        end
        check_output("alt chk_err", DATA_W'(b_chk_err), '0);
        @(negedge clock);
        b_inp_valid = 1'b0;
        b_chk_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
